// File: rtl/draw_sequencer_if.sv
// rtl/draw_sequencer_if.sv - draw engine handshake and vga_adapter write port bundle
interface draw_sequencer_if #(
  parameter int NUM_CH = 4,
  parameter int XW     = 10,
  parameter int CW     = 3
);
  logic [NUM_CH-1:0]    ch_go;
  logic [NUM_CH-1:0]    ch_done;
  logic [NUM_CH-1:0]    ch_we;
  logic [NUM_CH*XW-1:0] ch_x;
  logic [NUM_CH*XW-1:0] ch_y;
  logic [NUM_CH*CW-1:0] ch_colour;
  logic [XW-1:0]        vga_x;
  logic [XW-1:0]        vga_y;
  logic [CW-1:0]        vga_colour;
  logic                 vga_we;

  modport master (
    output ch_go, vga_x, vga_y, vga_colour, vga_we,
    input  ch_done, ch_we, ch_x, ch_y, ch_colour
  );

  modport slave (
    input  ch_go, vga_x, vga_y, vga_colour, vga_we,
    output ch_done, ch_we, ch_x, ch_y, ch_colour
  );
endinterface

// File: rtl/draw_sequencer.sv
// rtl/draw_sequencer.sv - frame scheduler running erase/logic/increment/draw passes over draw engines
module draw_sequencer #(
  parameter int             NUM_CH    = 4,
  parameter int             CHW       = 2,
  parameter int             XW        = 10,
  parameter int             CW        = 3,
  parameter int             TW        = 20,
  parameter int             LOGIC_TO  = 30,
  parameter logic [CW-1:0]  BG_COLOUR = '0
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 i_frame_tick,
  input  logic                 i_erase_en,
  input  logic [NUM_CH-1:0]    i_ch_mask,
  input  logic [NUM_CH*TW-1:0] i_ch_timeout,
  draw_sequencer_if.master     bus,
  output logic                 o_logic_go,
  input  logic                 i_logic_done,
  output logic                 o_inc_enable,
  output logic                 o_busy,
  output logic                 o_pass,
  output logic [CHW-1:0]       o_active_ch,
  output logic [NUM_CH-1:0]    o_timeout_flag,
  output logic                 o_overrun
);

  // One extra index bit so "past the last channel" never aliases channel 0.
  localparam int IW = CHW + 1;

  typedef enum logic [2:0] {
    S_IDLE, S_SEL, S_GO, S_WAIT, S_LOGIC, S_LOGIC_WAIT, S_INC
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [IW-1:0]       r_idx;
  logic                r_pass;
  logic [TW-1:0]       r_cnt;
  logic [NUM_CH-1:0]   r_tflag;
  logic                r_overrun;
  logic [XW-1:0]       r_vx;
  logic [XW-1:0]       r_vy;
  logic [CW-1:0]       r_vc;

  logic [CHW-1:0]      w_a;
  logic [XW-1:0]       w_sx;
  logic [XW-1:0]       w_sy;
  logic [CW-1:0]       w_sc;
  logic                w_swe;
  logic                w_done_a;
  logic [TW-1:0]       w_sto;
  logic                w_to_hit;
  logic                w_found;
  logic [IW-1:0]       w_sel;

  assign w_a = r_idx[CHW-1:0];

  always_comb begin
    w_sx     = '0;
    w_sy     = '0;
    w_sc     = '0;
    w_swe    = 1'b0;
    w_done_a = 1'b0;
    w_sto    = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (w_a == CHW'(i)) begin
        w_sx     = bus.ch_x[i*XW +: XW];
        w_sy     = bus.ch_y[i*XW +: XW];
        w_sc     = bus.ch_colour[i*CW +: CW];
        w_swe    = bus.ch_we[i];
        w_done_a = bus.ch_done[i];
        w_sto    = i_ch_timeout[i*TW +: TW];
      end
    end
  end

  assign w_to_hit = (r_cnt == w_sto);

  // Lowest enabled channel at or above the current index; descending loop leaves the lowest.
  always_comb begin
    w_found = 1'b0;
    w_sel   = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (i_ch_mask[i] && (IW'(i) >= r_idx)) begin
        w_found = 1'b1;
        w_sel   = IW'(i);
      end
    end
  end

  always_comb begin
    w_next         = r_state;
    bus.ch_go      = '0;
    o_logic_go     = 1'b0;
    o_inc_enable   = 1'b0;
    bus.vga_x      = r_vx;
    bus.vga_y      = r_vy;
    bus.vga_colour = r_vc;
    bus.vga_we     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_frame_tick) w_next = i_erase_en ? S_SEL : S_LOGIC;
      end
      S_SEL: begin
        if (w_found)     w_next = S_GO;
        else if (r_pass) w_next = S_IDLE;
        else             w_next = S_LOGIC;
      end
      S_GO: begin
        for (int i = 0; i < NUM_CH; i++) begin
          if (w_a == CHW'(i)) bus.ch_go[i] = 1'b1;
        end
        w_next = S_WAIT;
      end
      S_WAIT: begin
        bus.vga_x      = w_sx;
        bus.vga_y      = w_sy;
        bus.vga_colour = r_pass ? w_sc : BG_COLOUR;
        bus.vga_we     = w_swe;
        if (w_done_a || w_to_hit) w_next = S_SEL;
      end
      S_LOGIC: begin
        o_logic_go = 1'b1;
        w_next     = S_LOGIC_WAIT;
      end
      S_LOGIC_WAIT: begin
        if (i_logic_done || (r_cnt == TW'(LOGIC_TO))) w_next = S_INC;
      end
      S_INC: begin
        o_inc_enable = 1'b1;
        w_next       = S_SEL;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state   <= S_IDLE;
      r_idx     <= '0;
      r_pass    <= 1'b0;
      r_cnt     <= '0;
      r_tflag   <= '0;
      r_overrun <= 1'b0;
      r_vx      <= '0;
      r_vy      <= '0;
      r_vc      <= '0;
    end else begin
      r_state <= w_next;
      if (i_frame_tick && (r_state != S_IDLE)) r_overrun <= 1'b1;
      case (r_state)
        S_IDLE: begin
          if (i_frame_tick) begin
            r_pass <= 1'b0;
            r_idx  <= '0;
          end
        end
        S_SEL: begin
          if (w_found) r_idx <= w_sel;
        end
        S_GO, S_LOGIC: begin
          r_cnt <= '0;
        end
        S_WAIT: begin
          r_cnt <= r_cnt + TW'(1);
          r_vx  <= w_sx;
          r_vy  <= w_sy;
          r_vc  <= r_pass ? w_sc : BG_COLOUR;
          if (w_done_a || w_to_hit) r_idx <= r_idx + IW'(1);
          // A done arriving on the budget's last cycle still counts as on time.
          if (!w_done_a && w_to_hit) begin
            for (int i = 0; i < NUM_CH; i++) begin
              if (w_a == CHW'(i)) r_tflag[i] <= 1'b1;
            end
          end
        end
        S_LOGIC_WAIT: begin
          r_cnt <= r_cnt + TW'(1);
        end
        S_INC: begin
          r_pass <= 1'b1;
          r_idx  <= '0;
        end
        default: ;
      endcase
    end
  end

  assign o_busy         = (r_state != S_IDLE);
  assign o_pass         = r_pass;
  assign o_active_ch    = w_a;
  assign o_timeout_flag = r_tflag;
  assign o_overrun      = r_overrun;

endmodule

// File: tb/tb_draw_sequencer.sv
// tb/tb_draw_sequencer.sv - table-driven frame checks plus overrun and mid-frame reset sequences
module tb_draw_sequencer;
  localparam int NUM_CH = 3;
  localparam int CHW    = 2;
  localparam int XW     = 10;
  localparam int CW     = 3;
  localparam int TW     = 20;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic frame_tick = 1'b0;
  logic erase_en = 1'b0;
  logic [NUM_CH-1:0] ch_mask = '0;
  logic [NUM_CH*TW-1:0] ch_timeout = '0;
  logic logic_go, logic_done, inc_enable, busy, pass, overrun;
  logic [CHW-1:0] active_ch;
  logic [NUM_CH-1:0] timeout_flag;

  draw_sequencer_if #(.NUM_CH(NUM_CH), .XW(XW), .CW(CW)) bus ();

  draw_sequencer #(.NUM_CH(NUM_CH), .CHW(CHW), .XW(XW), .CW(CW), .TW(TW),
                   .LOGIC_TO(30), .BG_COLOUR(3'b000)) dut (
    .clk(clk), .resetn(resetn), .i_frame_tick(frame_tick), .i_erase_en(erase_en),
    .i_ch_mask(ch_mask), .i_ch_timeout(ch_timeout), .bus(bus),
    .o_logic_go(logic_go), .i_logic_done(logic_done), .o_inc_enable(inc_enable),
    .o_busy(busy), .o_pass(pass), .o_active_ch(active_ch),
    .o_timeout_flag(timeout_flag), .o_overrun(overrun)
  );

  always #5 clk = ~clk;

  int errs = 0;
  int checks = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Engine models: done pulses dly cycles after go (0 = never), fixed pixel data per channel.
  int dly[NUM_CH];
  int rem[NUM_CH];
  int ldly = 0;
  int lrem = 0;
  initial begin
    bus.ch_done = '0;
    bus.ch_we   = '1;
    logic_done  = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      bus.ch_x[i*XW +: XW]      = XW'(100 + i);
      bus.ch_y[i*XW +: XW]      = XW'(200 + i);
      bus.ch_colour[i*CW +: CW] = CW'(i + 1);
      dly[i] = 4;
      rem[i] = 0;
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < NUM_CH; i++) begin
      bus.ch_done[i] = 1'b0;
      if (bus.ch_go[i]) rem[i] = dly[i];
      else if (rem[i] > 0) begin
        rem[i] = rem[i] - 1;
        if (rem[i] == 0) bus.ch_done[i] = 1'b1;
      end
    end
    logic_done = 1'b0;
    if (logic_go) lrem = ldly;
    else if (lrem > 0) begin
      lrem = lrem - 1;
      if (lrem == 0) logic_done = 1'b1;
    end
  end

  // Frame monitor: event order (ch index, 8=logic_go, 9=inc_enable), write counts, pixel checks.
  logic [63:0] obs;
  int nev, first_cyc, lg_cyc, inc_cyc, cur, bad, gos;
  int wecnt[NUM_CH];
  always @(negedge clk) begin
    for (int i = 0; i < NUM_CH; i++) begin
      if (bus.ch_go[i]) begin
        obs = {obs[59:0], 4'(i)}; nev++; gos++; cur = i;
        if (first_cyc < 0) first_cyc = cyc;
      end
    end
    if (logic_go) begin
      obs = {obs[59:0], 4'h8}; nev++; lg_cyc = cyc;
      if (first_cyc < 0) first_cyc = cyc;
    end
    if (inc_enable) begin
      obs = {obs[59:0], 4'h9}; nev++; inc_cyc = cyc;
    end
    if (bus.vga_we) begin
      wecnt[cur]++;
      if (int'(bus.vga_x) != 100 + cur || int'(bus.vga_y) != 200 + cur) bad++;
      if (pass == 1'b0 && bus.vga_colour != 3'b000) bad++;
      if (pass == 1'b1 && int'(bus.vga_colour) != cur + 1) bad++;
    end
  end

  task automatic clear_mon();
    obs = '0; nev = 0; first_cyc = -1; lg_cyc = 0; inc_cyc = 0; cur = 0; bad = 0; gos = 0;
    for (int i = 0; i < NUM_CH; i++) wecnt[i] = 0;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
  endtask

  int t_tick;
  task automatic pulse_tick();
    t_tick = cyc;
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (busy && n < 600) begin
      @(negedge clk);
      n++;
    end
    if (busy) chk({name, "_idle_timeout"}, 64'd1, 64'd0);
  endtask

  typedef struct {
    logic [2:0]  mask;
    logic        erase;
    int          d0, d1, d2, ld;
    int          t0, t1, t2;
    logic [63:0] seq;
    int          nev;
    int          lat;
    int          lgap;
    int          w0, w1, w2;
    logic [2:0]  flag;
    int          fx;
  } vec_t;

  vec_t v[7];

  initial begin
    v[0] = '{3'b111, 1'b1, 4, 4, 4, 5, 50, 50, 50, 64'h01289012, 8, 2, 6, 8, 8, 8, 3'b000, 102};
    v[1] = '{3'b101, 1'b1, 4, 4, 4, 0, 50, 50, 50, 64'h028902, 6, 2, 32, 8, 0, 8, 3'b000, 102};
    v[2] = '{3'b111, 1'b1, 4, 0, 4, 5, 50, 20, 50, 64'h01289012, 8, 2, 6, 8, 42, 8, 3'b010, 102};
    v[3] = '{3'b001, 1'b0, 4, 4, 4, 5, 50, 50, 50, 64'h890, 3, 1, 6, 4, 0, 0, 3'b000, 100};
    v[4] = '{3'b000, 1'b1, 4, 4, 4, 5, 50, 50, 50, 64'h89, 2, 2, 6, 0, 0, 0, 3'b000, 0};
    v[5] = '{3'b111, 1'b1, 0, 4, 4, 5, 0, 50, 50, 64'h01289012, 8, 2, 6, 2, 8, 8, 3'b001, 102};
    v[6] = '{3'b111, 1'b1, 1, 4, 4, 5, 0, 50, 50, 64'h01289012, 8, 2, 6, 2, 8, 8, 3'b000, 102};

    clear_mon();
    repeat (2) @(negedge clk);
    chk("rst_busy", 64'(busy), 0);
    chk("rst_pass", 64'(pass), 0);
    chk("rst_active_ch", 64'(active_ch), 0);
    chk("rst_timeout_flag", 64'(timeout_flag), 0);
    chk("rst_overrun", 64'(overrun), 0);
    chk("rst_vga", {bus.vga_x, bus.vga_y, bus.vga_colour, bus.vga_we}, 0);
    chk("rst_pulses", {bus.ch_go, logic_go, inc_enable}, 0);
    resetn = 1'b1;
    @(negedge clk);

    for (int k = 0; k < 7; k++) begin
      string nm;
      nm = $sformatf("v%0d", k);
      do_reset();
      ch_mask = v[k].mask;
      erase_en = v[k].erase;
      dly[0] = v[k].d0; dly[1] = v[k].d1; dly[2] = v[k].d2; ldly = v[k].ld;
      ch_timeout = {TW'(v[k].t2), TW'(v[k].t1), TW'(v[k].t0)};
      clear_mon();
      pulse_tick();
      wait_idle(nm);
      @(negedge clk);
      chk({nm, "_seq"}, obs, v[k].seq);
      chk({nm, "_nev"}, 64'(nev), 64'(v[k].nev));
      chk({nm, "_first_latency"}, 64'(first_cyc - t_tick), 64'(v[k].lat));
      chk({nm, "_logic_to_inc"}, 64'(inc_cyc - lg_cyc), 64'(v[k].lgap));
      chk({nm, "_we_ch0"}, 64'(wecnt[0]), 64'(v[k].w0));
      chk({nm, "_we_ch1"}, 64'(wecnt[1]), 64'(v[k].w1));
      chk({nm, "_we_ch2"}, 64'(wecnt[2]), 64'(v[k].w2));
      chk({nm, "_pixel_errors"}, 64'(bad), 0);
      chk({nm, "_timeout_flag"}, 64'(timeout_flag), 64'(v[k].flag));
      chk({nm, "_hold_x"}, 64'(bus.vga_x), 64'(v[k].fx));
      chk({nm, "_idle_we"}, 64'(bus.vga_we), 0);
      chk({nm, "_overrun"}, 64'(overrun), 0);
    end

    // Tick while busy: dropped, overrun sticks, frame runs to completion once.
    do_reset();
    ch_mask = 3'b111; erase_en = 1'b1; ldly = 5;
    dly[0] = 4; dly[1] = 4; dly[2] = 4;
    ch_timeout = {TW'(50), TW'(50), TW'(50)};
    clear_mon();
    pulse_tick();
    repeat (10) @(negedge clk);
    pulse_tick();
    wait_idle("overrun");
    repeat (3) @(negedge clk);
    chk("overrun_flag", 64'(overrun), 1);
    chk("overrun_seq", obs, 64'h01289012);
    chk("overrun_no_restart", 64'(busy), 0);

    // Reset in the middle of a WAIT on channel 1 with overrun already set.
    do_reset();
    clear_mon();
    pulse_tick();
    repeat (3) @(negedge clk);
    pulse_tick();
    begin
      int n;
      n = 0;
      while (!(bus.vga_we && active_ch == 2'd1) && n < 200) begin
        @(negedge clk);
        n++;
      end
      chk("midreset_reached_wait", 64'(bus.vga_we && active_ch == 2'd1), 1);
    end
    chk("midreset_overrun_before", 64'(overrun), 1);
    resetn = 1'b0;
    @(negedge clk);
    chk("midreset_busy", 64'(busy), 0);
    chk("midreset_we", 64'(bus.vga_we), 0);
    chk("midreset_flags", {timeout_flag, overrun}, 0);
    chk("midreset_vga_x", 64'(bus.vga_x), 0);
    gos = 0;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    repeat (10) @(negedge clk);
    chk("midreset_no_go", 64'(gos), 0);
    chk("midreset_stays_idle", 64'(busy), 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1);
  end
endmodule
